// File: rtl/write_addr_alloc.sv
// Free-block allocator for the shared cache SRAM: reserves blocks per packet,
// streams one block address per cycle, reports cell links and recycles freed blocks.
module write_addr_alloc #(
  parameter int BLK_ADDR_WIDTH = 6,
  parameter int LEN_WIDTH      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_pkt_vld,
  input  logic [LEN_WIDTH-1:0]      i_pkt_len,
  output logic                      o_pkt_rdy,
  output logic [BLK_ADDR_WIDTH-1:0] o_sram_addr,
  output logic                      o_sram_addr_vld,
  output logic                      o_link_vld,
  output logic [BLK_ADDR_WIDTH-1:0] o_link_prev,
  output logic [BLK_ADDR_WIDTH-1:0] o_link_next,
  output logic                      o_pkt_done,
  output logic [BLK_ADDR_WIDTH-1:0] o_pkt_head,
  input  logic                      i_free_vld,
  input  logic [BLK_ADDR_WIDTH-1:0] i_free_addr,
  output logic                      o_free_ovf,
  output logic [BLK_ADDR_WIDTH:0]   o_avail_cnt,
  output logic                      o_init_done
);

  localparam int NUM_BLK = 2 ** BLK_ADDR_WIDTH;
  localparam int CNT_W   = BLK_ADDR_WIDTH + 1;

  localparam logic [BLK_ADDR_WIDTH-1:0] PTR_ONE  = BLK_ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(NUM_BLK);
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(NUM_BLK - 1);
  localparam logic [LEN_WIDTH-1:0]      LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]      LEN_TWO  = LEN_WIDTH'(2);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ALLOC} state_t;

  state_t                    state;
  logic [BLK_ADDR_WIDTH-1:0] free_list [NUM_BLK];
  logic [BLK_ADDR_WIDTH-1:0] rd_ptr, wr_ptr, pop_data;
  logic [CNT_W-1:0]          avail_cnt, fill_cnt, len_ext, accept_len;
  logic [LEN_WIDTH-1:0]      remaining;
  logic                      accept, pop_first, pop_next, pop;
  logic                      list_full, push, drop;

  assign len_ext    = CNT_W'(i_pkt_len);
  assign o_pkt_rdy  = o_init_done && (len_ext <= avail_cnt) &&
                      (state == S_IDLE || (state == S_ALLOC && remaining == LEN_ONE));
  assign accept     = i_pkt_vld && o_pkt_rdy;
  assign accept_len = accept ? len_ext : '0;
  assign pop_first  = accept && (i_pkt_len != '0);
  // A chained accept only happens when remaining==1, so the two pop sources never overlap.
  assign pop_next   = (state == S_ALLOC) && (remaining > LEN_ONE);
  assign pop        = pop_first || pop_next;
  assign pop_data   = free_list[rd_ptr];

  // fill_cnt tracks entries not yet popped; it gates returns, not avail_cnt.
  assign list_full  = (fill_cnt == CNT_FULL);
  assign push       = i_free_vld && (state != S_INIT) && !list_full;
  assign drop       = i_free_vld && (state != S_INIT) && list_full;

  assign o_avail_cnt = avail_cnt;

  // NOTE: the list RAM has no reset; INIT rewrites every entry before any pop can read it.
  always_ff @(posedge i_clk) begin
    if (state == S_INIT) begin
      free_list[wr_ptr] <= wr_ptr;
    end else if (push) begin
      free_list[wr_ptr] <= i_free_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= S_INIT;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      avail_cnt       <= '0;
      fill_cnt        <= '0;
      remaining       <= '0;
      o_init_done     <= 1'b0;
      o_sram_addr     <= '0;
      o_sram_addr_vld <= 1'b0;
      o_link_vld      <= 1'b0;
      o_link_prev     <= '0;
      o_link_next     <= '0;
      o_pkt_done      <= 1'b0;
      o_pkt_head      <= '0;
      o_free_ovf      <= 1'b0;
    end else begin
      o_sram_addr_vld <= pop;
      o_link_vld      <= pop_next;
      o_pkt_done      <= (pop_first && i_pkt_len == LEN_ONE) ||
                         (pop_next && remaining == LEN_TWO);
      o_free_ovf      <= drop;

      if (pop) o_sram_addr <= pop_data;
      if (pop_first) o_pkt_head <= pop_data;
      if (pop_next) begin
        o_link_prev <= o_sram_addr;
        o_link_next <= pop_data;
      end

      if (state == S_INIT) begin
        wr_ptr    <= wr_ptr + PTR_ONE;
        avail_cnt <= avail_cnt + CNT_W'(1);
        fill_cnt  <= fill_cnt + CNT_W'(1);
        if (avail_cnt == CNT_LAST) begin
          state       <= S_IDLE;
          o_init_done <= 1'b1;
        end
      end else begin
        if (pop_first) begin
          state     <= S_ALLOC;
          remaining <= i_pkt_len;
        end else if (state == S_ALLOC) begin
          remaining <= remaining - LEN_ONE;
          if (remaining == LEN_ONE) state <= S_IDLE;
        end
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        avail_cnt <= avail_cnt - accept_len + CNT_W'(push);
        fill_cnt  <= fill_cnt + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_write_addr_alloc.sv
// Directed bench for write_addr_alloc: per-cycle vector table plus hand-written
// sequences for init timing, drain/refill and mid-packet reset.
module tb_write_addr_alloc;

  localparam int W  = 6;
  localparam int LW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_pkt_vld = 1'b0;
  logic [LW-1:0] i_pkt_len = '0;
  logic          i_free_vld = 1'b0;
  logic [W-1:0]  i_free_addr = '0;
  logic          o_pkt_rdy, o_sram_addr_vld, o_link_vld, o_pkt_done, o_free_ovf, o_init_done;
  logic [W-1:0]  o_sram_addr, o_link_prev, o_link_next, o_pkt_head;
  logic [W:0]    o_avail_cnt;

  int n_pass  = 0;
  int n_total = 0;

  write_addr_alloc #(.BLK_ADDR_WIDTH(W), .LEN_WIDTH(LW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pkt_vld(i_pkt_vld), .i_pkt_len(i_pkt_len), .o_pkt_rdy(o_pkt_rdy),
    .o_sram_addr(o_sram_addr), .o_sram_addr_vld(o_sram_addr_vld),
    .o_link_vld(o_link_vld), .o_link_prev(o_link_prev), .o_link_next(o_link_next),
    .o_pkt_done(o_pkt_done), .o_pkt_head(o_pkt_head),
    .i_free_vld(i_free_vld), .i_free_addr(i_free_addr), .o_free_ovf(o_free_ovf),
    .o_avail_cnt(o_avail_cnt), .o_init_done(o_init_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          pkt_vld;
    logic [LW-1:0] pkt_len;
    logic          free_vld;
    logic [W-1:0]  free_addr;
    logic          rdy;
    logic          vld;
    logic [W-1:0]  addr;
    logic          lnk;
    logic [W-1:0]  prev;
    logic [W-1:0]  next;
    logic          done;
    logic [W-1:0]  head;
    logic [W:0]    avail;
    logic          ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},   32'(o_pkt_rdy), 0);
    check({tag, "_vld"},   32'(o_sram_addr_vld), 0);
    check({tag, "_addr"},  32'(o_sram_addr), 0);
    check({tag, "_lnk"},   32'(o_link_vld), 0);
    check({tag, "_prev"},  32'(o_link_prev), 0);
    check({tag, "_next"},  32'(o_link_next), 0);
    check({tag, "_done"},  32'(o_pkt_done), 0);
    check({tag, "_head"},  32'(o_pkt_head), 0);
    check({tag, "_ovf"},   32'(o_free_ovf), 0);
    check({tag, "_avail"}, 32'(o_avail_cnt), 0);
    check({tag, "_initd"}, 32'(o_init_done), 0);
  endtask

  // Starts at posedge+1 with reset asserted; releases it and times INIT.
  task automatic release_and_init(input logic hold_free);
    int cyc, dones, ovfs;
    cyc = 0; dones = 0; ovfs = 0;
    @(posedge i_clk); #1;
    i_rst_n     = 1'b1;
    i_free_vld  = hold_free;
    i_free_addr = 6'd5;
    for (int k = 1; k <= 100; k++) begin
      @(posedge i_clk); #1;
      if (o_pkt_done) dones++;
      if (o_free_ovf) ovfs++;
      if (o_init_done) begin
        cyc = k;
        break;
      end
    end
    i_free_vld = 1'b0;
    check("init_cycles", cyc, 64);
    check("init_avail", 32'(o_avail_cnt), 64);
    check("init_no_done", dones, 0);
    check("init_no_ovf", ovfs, 0);
    check("init_vld", 32'(o_sram_addr_vld), 0);
    check("init_lnk", 32'(o_link_vld), 0);
  endtask

  // Sends a packet whose blocks are expected to be first..first+len-1; ends at posedge+1.
  task automatic send_pkt(input int len, input int first);
    int waited;
    waited = 0;
    i_pkt_vld = 1'b1;
    i_pkt_len = LW'(len);
    #1;
    while (!o_pkt_rdy && waited < 20) begin
      @(posedge i_clk); #2;
      waited++;
    end
    check("pkt_rdy_wait", 32'(o_pkt_rdy), 1);
    @(posedge i_clk); #1;
    i_pkt_vld = 1'b0;
    i_pkt_len = '0;
    for (int i = 0; i < len; i++) begin
      check("pkt_vld", 32'(o_sram_addr_vld), 1);
      check("pkt_addr", 32'(o_sram_addr), 32'((first + i) % 64));
      check("pkt_lnk", 32'(o_link_vld), (i > 0) ? 1 : 0);
      if (i > 0) begin
        check("pkt_prev", 32'(o_link_prev), 32'((first + i - 1) % 64));
        check("pkt_next", 32'(o_link_next), 32'((first + i) % 64));
      end
      check("pkt_done", 32'(o_pkt_done), (i == len - 1) ? 1 : 0);
      @(posedge i_clk); #1;
    end
    check("pkt_idle", 32'(o_sram_addr_vld), 0);
  endtask

  initial begin
    int exp_addr [5];

    // pv len fv fa | rdy vld addr lnk prev next done head avail ovf
    vecs[0]  = '{1'b0, 4'd0, 1'b1, 6'd7, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 7'd64, 1'b0};
    vecs[1]  = '{1'b0, 4'd0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 7'd64, 1'b1};
    vecs[2]  = '{1'b1, 4'd3, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 7'd64, 1'b0};
    vecs[3]  = '{1'b1, 4'd2, 1'b0, 6'd0, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd0, 7'd61, 1'b0};
    vecs[4]  = '{1'b1, 4'd2, 1'b0, 6'd0, 1'b0, 1'b1, 6'd1, 1'b1, 6'd0, 6'd1, 1'b0, 6'd0, 7'd61, 1'b0};
    vecs[5]  = '{1'b1, 4'd2, 1'b0, 6'd0, 1'b1, 1'b1, 6'd2, 1'b1, 6'd1, 6'd2, 1'b1, 6'd0, 7'd61, 1'b0};
    vecs[6]  = '{1'b0, 4'd0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd3, 1'b0, 6'd0, 6'd0, 1'b0, 6'd3, 7'd59, 1'b0};
    vecs[7]  = '{1'b0, 4'd0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd4, 1'b1, 6'd3, 6'd4, 1'b1, 6'd3, 7'd59, 1'b0};
    vecs[8]  = '{1'b1, 4'd1, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd3, 7'd59, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd5, 1'b0, 6'd0, 6'd0, 1'b1, 6'd5, 7'd59, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 6'd0, 1'b0, 6'd5, 7'd59, 1'b0};

    repeat (70) @(posedge i_clk);
    #1;
    check_all_zero("rst");
    release_and_init(1'b0);

    // Overflow return, len=3 then chained len=2, then accept+return in one cycle.
    for (int i = 0; i < 11; i++) begin
      i_pkt_vld   = vecs[i].pkt_vld;
      i_pkt_len   = vecs[i].pkt_len;
      i_free_vld  = vecs[i].free_vld;
      i_free_addr = vecs[i].free_addr;
      #1;
      check($sformatf("v%0d_rdy", i), 32'(o_pkt_rdy), 32'(vecs[i].rdy));
      check($sformatf("v%0d_vld", i), 32'(o_sram_addr_vld), 32'(vecs[i].vld));
      if (vecs[i].vld) check($sformatf("v%0d_addr", i), 32'(o_sram_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d_lnk", i), 32'(o_link_vld), 32'(vecs[i].lnk));
      if (vecs[i].lnk) begin
        check($sformatf("v%0d_prev", i), 32'(o_link_prev), 32'(vecs[i].prev));
        check($sformatf("v%0d_next", i), 32'(o_link_next), 32'(vecs[i].next));
      end
      check($sformatf("v%0d_done", i), 32'(o_pkt_done), 32'(vecs[i].done));
      check($sformatf("v%0d_head", i), 32'(o_pkt_head), 32'(vecs[i].head));
      check($sformatf("v%0d_avail", i), 32'(o_avail_cnt), 32'(vecs[i].avail));
      check($sformatf("v%0d_ovf", i), 32'(o_free_ovf), 32'(vecs[i].ovf));
      @(posedge i_clk); #1;
    end
    i_pkt_vld = 1'b0; i_pkt_len = '0; i_free_vld = 1'b0;

    // Drain blocks 6..62, leaving entries holding 63 and 0.
    send_pkt(15, 6);
    send_pkt(15, 21);
    send_pkt(15, 36);
    send_pkt(12, 51);
    check("drain_avail", 32'(o_avail_cnt), 2);

    // len=5 blocked until three returns land, then served in list order.
    i_pkt_vld = 1'b1; i_pkt_len = 4'd5;
    #1;
    check("drain_rdy0", 32'(o_pkt_rdy), 0);
    for (int r = 0; r < 3; r++) begin
      @(posedge i_clk); #1;
      i_free_vld = 1'b1; i_free_addr = W'(10 + r);
      #1;
      check("refill_rdy0", 32'(o_pkt_rdy), 0);
      check("refill_avail", 32'(o_avail_cnt), 32'(2 + r));
    end
    @(posedge i_clk); #1;
    i_free_vld = 1'b0;
    #1;
    check("refill_rdy1", 32'(o_pkt_rdy), 1);
    @(posedge i_clk); #1;
    i_pkt_vld = 1'b0; i_pkt_len = '0;
    exp_addr = '{63, 0, 10, 11, 12};
    for (int i = 0; i < 5; i++) begin
      check("refill_vld", 32'(o_sram_addr_vld), 1);
      check("refill_addr", 32'(o_sram_addr), 32'(exp_addr[i]));
      check("refill_done", 32'(o_pkt_done), (i == 4) ? 1 : 0);
      @(posedge i_clk); #1;
    end
    check("refill_head", 32'(o_pkt_head), 63);
    check("refill_avail0", 32'(o_avail_cnt), 0);

    // Return four blocks, start a len=4 packet and reset during its second cell.
    for (int r = 0; r < 4; r++) begin
      i_free_vld = 1'b1; i_free_addr = W'(20 + r);
      @(posedge i_clk); #1;
    end
    i_free_vld = 1'b0;
    i_pkt_vld = 1'b1; i_pkt_len = 4'd4;
    #1;
    check("rst_pkt_rdy", 32'(o_pkt_rdy), 1);
    @(posedge i_clk); #1;
    i_pkt_vld = 1'b0; i_pkt_len = '0;
    check("rst_pkt_c0", 32'(o_sram_addr), 20);
    @(posedge i_clk); #1;
    check("rst_pkt_c1", 32'(o_sram_addr), 21);
    check("rst_pkt_lnk", 32'(o_link_vld), 1);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (3) @(posedge i_clk);
    #1;
    check("midrst_hold_done", 32'(o_pkt_done), 0);
    release_and_init(1'b1);
    send_pkt(2, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/write_addr_alloc.md
Name: write_addr_alloc

Overview:
- Upstream neighbour of the SRAM write stage. Owns the free-block list of the shared cache SRAM.
- Accepts per-packet write requests carrying a cell count and reserves that many free blocks up front.
- Emits one block address per cycle on o_sram_addr/o_sram_addr_vld; each valid also serves as the cell-FIFO read strobe in the write stage.
- Reports cell-to-cell links for the packet chain, and takes freed blocks back from the read side.

Parameters:
BLK_ADDR_WIDTH, 6, block address width; must equal `BLK_ADDR_WIDTH; NUM_BLK = 2**BLK_ADDR_WIDTH.
LEN_WIDTH, 4, width of packet length field, counted in cells.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  asynchronous active-low reset.
i_pkt_vld  input  1  packet write request valid.
i_pkt_len  input  LEN_WIDTH  cells in packet.
o_pkt_rdy  output  1  request accepted when i_pkt_vld && o_pkt_rdy.
o_sram_addr  output  BLK_ADDR_WIDTH  block address for current cell.
o_sram_addr_vld  output  1  one cell written this cycle.
o_link_vld  output  1  link-table write strobe.
o_link_prev  output  BLK_ADDR_WIDTH  previous cell block of packet.
o_link_next  output  BLK_ADDR_WIDTH  following cell block of packet.
o_pkt_done  output  1  one-cycle pulse on last cell of a packet.
o_pkt_head  output  BLK_ADDR_WIDTH  first block of packet, valid with o_pkt_done.
i_free_vld  input  1  return one block to free list.
i_free_addr  input  BLK_ADDR_WIDTH  block being returned.
o_free_ovf  output  1  one-cycle pulse: return dropped, list full.
o_avail_cnt  output  BLK_ADDR_WIDTH+1  unreserved free blocks.
o_init_done  output  1  free list initialised.

Behaviour:
- Reset (async, i_rst_n low): every output is 0. State INIT; rd_ptr=wr_ptr=0; avail_cnt=0.
- Reset mid-packet aborts the packet. No o_pkt_done is issued, and INIT restarts on release.
- Free list: circular RAM of NUM_BLK entries plus rd_ptr/wr_ptr, each BLK_ADDR_WIDTH wide with natural wrap.

INIT state:
- Writes value k into entry k for k=0..NUM_BLK-1, one entry per cycle, incrementing avail_cnt.
- After NUM_BLK cycles: avail_cnt=NUM_BLK, wr_ptr has wrapped to 0, o_init_done=1 (stays 1 until reset), state goes to IDLE.
- During INIT: o_pkt_rdy=0, and i_free_vld is ignored without a pulse.

o_pkt_rdy (combinational):
- High when o_init_done && i_pkt_len <= avail_cnt && (state==IDLE || (state==ALLOC && remaining==1)).
- The ALLOC term allows back-to-back packets with no gap cycle.

Accept at cycle T:
- avail_cnt decreases by i_pkt_len. remaining is loaded with i_pkt_len.
- Cycles T+1..T+len: o_sram_addr_vld=1 and o_sram_addr = list[rd_ptr], with rd_ptr advancing 1 per cycle.
- The addresses are registered outputs and are never stalled, because the blocks are already reserved.
- First cell: o_pkt_head is latched.
- Each cell after the first: o_link_vld=1, o_link_prev = previous cell address, o_link_next = current address.
- Last cell (cycle T+len): o_pkt_done=1 with o_pkt_head.
- Single-cell packet: no link, done on T+1.

i_pkt_len==0:
- Accepted when IDLE. No avail_cnt change, no addresses, no done. State stays IDLE.

Free return (IDLE or ALLOC):
- i_free_vld writes list[wr_ptr], wr_ptr++, avail_cnt+1, all visible next cycle.
- Simultaneous accept and return: avail_cnt <= avail_cnt - len + 1 in one update.
- Simultaneous pop and push on the same entry is legal. The pop reads the old content; the pushed entry becomes poppable from the next cycle.
- Return while the list is full (count of blocks not popped == NUM_BLK): the write is dropped, pointers and count are unchanged, and o_free_ovf pulses 1 cycle.

FSM:
- INIT -> IDLE after NUM_BLK cycles.
- IDLE -> ALLOC on accept with len>0.
- ALLOC -> ALLOC on a chained accept in its last cycle.
- ALLOC -> IDLE after the last cell otherwise.

Test Plan:
- Reset, hold 70 cycles -> o_init_done rises exactly 64 cycles after reset release; o_avail_cnt=64; all other outputs 0.
- Packet len=3 after init -> o_sram_addr 0,1,2 on three consecutive cycles; links (0,1),(1,2); o_pkt_done with head=0 on the third cycle; avail=61.
- Packet len=2 held valid in the last cycle of a len=3 packet -> accepted that cycle; addresses 3,4 follow with no gap; head=3.
- Drain to avail=2, request len=5 -> o_pkt_rdy=0. Return 3 blocks (addrs 10,11,12) -> rdy rises; the packet receives the remaining list order ending 10,11,12.
- After init, return addr 7 with nothing allocated -> o_free_ovf pulses once; avail stays 64.
- Assert reset during the 2nd cell of a len=4 packet -> outputs 0 immediately, no o_pkt_done, INIT repeats, avail=64 afterwards.
